id_ex_pipe: RTL and testbench

ID_EX_PIPE -- requirements
Module: id_ex_pipe

---
 rtl/id_ex_pipe.sv | 172 +++++++++++++++++
 tb/tb_id_ex_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use interlock, flush-driven bubbles and a
// saturating bubble counter. A bubble is an all-zero slot with ALU class 3'b111.
module id_ex_pipe #(
    parameter int XLEN   = 32,
    parameter int BCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              id_valid,
    input  logic              id_br,
    input  logic              id_mem_read,
    input  logic              id_mem2reg,
    input  logic              id_mem_write,
    input  logic              id_br_addr_mode,
    input  logic              id_regs_write,
    input  logic [2:0]        id_alu_op,
    input  logic [1:0]        id_alu_src1,
    input  logic [1:0]        id_alu_src2,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [2:0]        id_funct3,
    input  logic [6:0]        id_funct7,

    input  logic              ex_flush,

    output logic              ex_valid,
    output logic              ex_br,
    output logic              ex_mem_read,
    output logic              ex_mem2reg,
    output logic              ex_mem_write,
    output logic              ex_br_addr_mode,
    output logic              ex_regs_write,
    output logic [2:0]        ex_alu_op,
    output logic [1:0]        ex_alu_src1,
    output logic [1:0]        ex_alu_src2,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [2:0]        ex_funct3,
    output logic [6:0]        ex_funct7,

    output logic              hazard_stall,
    output logic [BCNT_W-1:0] bubble_cnt
);

    typedef struct packed {
        logic            valid;
        logic            br;
        logic            mem_read;
        logic            mem2reg;
        logic            mem_write;
        logic            br_addr_mode;
        logic            regs_write;
        logic [2:0]      alu_op;
        logic [1:0]      alu_src1;
        logic [1:0]      alu_src2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
    } ex_t;

    ex_t              ex_q, ex_d;
    ex_t              nop_c;
    ex_t              id_c;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic             hazard;
    logic             bubble;

    always_comb begin
        nop_c        = '0;
        nop_c.alu_op = 3'b111;
    end

    // Conservative: both source indices are compared whatever the format.
    always_comb begin
        hazard = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
                 ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
        bubble = ex_flush | hazard;
    end

    assign hazard_stall = hazard & ~ex_flush;

    always_comb begin
        id_c.valid        = id_valid;
        id_c.br           = id_br;
        id_c.mem_read     = id_mem_read;
        id_c.mem2reg      = id_mem2reg;
        id_c.mem_write    = id_mem_write;
        id_c.br_addr_mode = id_br_addr_mode;
        id_c.regs_write   = id_regs_write;
        id_c.alu_op       = id_alu_op;
        id_c.alu_src1     = id_alu_src1;
        id_c.alu_src2     = id_alu_src2;
        id_c.pc           = id_pc;
        id_c.rs1_data     = id_rs1_data;
        id_c.rs2_data     = id_rs2_data;
        id_c.imm          = id_imm;
        id_c.rs1          = id_rs1;
        id_c.rs2          = id_rs2;
        id_c.rd           = id_rd;
        id_c.funct3       = id_funct3;
        id_c.funct7       = id_funct7;
        // An empty ID slot must never reach EX with live write enables.
        if (!id_valid) begin
            id_c.br           = 1'b0;
            id_c.mem_read     = 1'b0;
            id_c.mem2reg      = 1'b0;
            id_c.mem_write    = 1'b0;
            id_c.br_addr_mode = 1'b0;
            id_c.regs_write   = 1'b0;
            id_c.alu_op       = 3'b111;
            id_c.alu_src1     = 2'b00;
            id_c.alu_src2     = 2'b00;
        end
    end

    always_comb begin
        ex_d   = bubble ? nop_c : id_c;
        bcnt_d = bcnt_q;
        if (bubble && (bcnt_q != {BCNT_W{1'b1}})) begin
            bcnt_d = bcnt_q + BCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q   <= nop_c;
            bcnt_q <= '0;
        end else begin
            ex_q   <= ex_d;
            bcnt_q <= bcnt_d;
        end
    end

    assign ex_valid        = ex_q.valid;
    assign ex_br           = ex_q.br;
    assign ex_mem_read     = ex_q.mem_read;
    assign ex_mem2reg      = ex_q.mem2reg;
    assign ex_mem_write    = ex_q.mem_write;
    assign ex_br_addr_mode = ex_q.br_addr_mode;
    assign ex_regs_write   = ex_q.regs_write;
    assign ex_alu_op       = ex_q.alu_op;
    assign ex_alu_src1     = ex_q.alu_src1;
    assign ex_alu_src2     = ex_q.alu_src2;
    assign ex_pc           = ex_q.pc;
    assign ex_rs1_data     = ex_q.rs1_data;
    assign ex_rs2_data     = ex_q.rs2_data;
    assign ex_imm          = ex_q.imm;
    assign ex_rs1          = ex_q.rs1;
    assign ex_rs2          = ex_q.rs2;
    assign ex_rd           = ex_q.rd;
    assign ex_funct3       = ex_q.funct3;
    assign ex_funct7       = ex_q.funct7;
    assign bubble_cnt      = bcnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: directed hazard/flush/reset cases then random traffic.
module tb_id_ex_pipe;
    localparam int XLEN   = 32;
    localparam int BCNT_W = 4;

    typedef struct packed {
        logic            valid;
        logic            br;
        logic            mem_read;
        logic            mem2reg;
        logic            mem_write;
        logic            br_addr_mode;
        logic            regs_write;
        logic [2:0]      alu_op;
        logic [1:0]      alu_src1;
        logic [1:0]      alu_src2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
    } ex_t;

    typedef struct {
        logic stall;
        ex_t  nxt;
        int   bcnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ex_flush = 1'b0;
    ex_t  id_s = '0;
    ex_t  dut_ex;

    logic              ex_valid, ex_br, ex_mem_read, ex_mem2reg, ex_mem_write;
    logic              ex_br_addr_mode, ex_regs_write;
    logic [2:0]        ex_alu_op;
    logic [1:0]        ex_alu_src1, ex_alu_src2;
    logic [XLEN-1:0]   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]        ex_rs1, ex_rs2, ex_rd;
    logic [2:0]        ex_funct3;
    logic [6:0]        ex_funct7;
    logic              hazard_stall;
    logic [BCNT_W-1:0] bubble_cnt;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;
    bit   stim_done = 1'b0;
    ex_t  m_ex;
    int   m_bcnt;
    logic last_stall;

    always #5 clk = ~clk;

    id_ex_pipe #(.XLEN(XLEN), .BCNT_W(BCNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_s.valid), .id_br(id_s.br), .id_mem_read(id_s.mem_read),
        .id_mem2reg(id_s.mem2reg), .id_mem_write(id_s.mem_write),
        .id_br_addr_mode(id_s.br_addr_mode), .id_regs_write(id_s.regs_write),
        .id_alu_op(id_s.alu_op), .id_alu_src1(id_s.alu_src1), .id_alu_src2(id_s.alu_src2),
        .id_pc(id_s.pc), .id_rs1_data(id_s.rs1_data), .id_rs2_data(id_s.rs2_data),
        .id_imm(id_s.imm), .id_rs1(id_s.rs1), .id_rs2(id_s.rs2), .id_rd(id_s.rd),
        .id_funct3(id_s.funct3), .id_funct7(id_s.funct7),
        .ex_flush(ex_flush),
        .ex_valid(ex_valid), .ex_br(ex_br), .ex_mem_read(ex_mem_read),
        .ex_mem2reg(ex_mem2reg), .ex_mem_write(ex_mem_write),
        .ex_br_addr_mode(ex_br_addr_mode), .ex_regs_write(ex_regs_write),
        .ex_alu_op(ex_alu_op), .ex_alu_src1(ex_alu_src1), .ex_alu_src2(ex_alu_src2),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
        .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
    );

    assign dut_ex = {ex_valid, ex_br, ex_mem_read, ex_mem2reg, ex_mem_write,
                     ex_br_addr_mode, ex_regs_write, ex_alu_op, ex_alu_src1, ex_alu_src2,
                     ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
                     ex_funct3, ex_funct7};

    function automatic ex_t nop_slot();
        ex_t n = '0;
        n.alu_op = 3'b111;
        return n;
    endfunction

    function automatic ex_t rand_id();
        logic [191:0] r;
        ex_t          t;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        t = ex_t'(r[$bits(ex_t)-1:0]);
        t.valid = ($urandom_range(0, 4) != 0);
        return t;
    endfunction

    function automatic ex_t mk_id(input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic mem_read);
        ex_t t = rand_id();
        t.valid    = 1'b1;
        t.rd       = rd;
        t.rs1      = rs1;
        t.rs2      = rs2;
        t.mem_read = mem_read;
        return t;
    endfunction

    // Reference: a load in EX blocks any valid ID instruction reading its
    // nonzero destination; flush or such a block turns the next EX slot into a bubble.
    task automatic step(input ex_t id, input logic flush, input logic r);
        exp_t e;
        logic depends;
        @(posedge clk);
        #2;
        id_s     = id;
        ex_flush = flush;
        rst      = r;
        depends  = m_ex.valid && m_ex.mem_read && (m_ex.rd != 5'd0) && id.valid &&
                   ((id.rs1 == m_ex.rd) || (id.rs2 == m_ex.rd));
        e.stall = depends && !flush;
        if (r) begin
            e.nxt  = nop_slot();
            m_bcnt = 0;
        end else if (flush || depends) begin
            e.nxt = nop_slot();
            if (m_bcnt < (1 << BCNT_W) - 1) m_bcnt = m_bcnt + 1;
        end else begin
            e.nxt = id;
            if (!id.valid) begin
                e.nxt.br           = 1'b0;
                e.nxt.mem_read     = 1'b0;
                e.nxt.mem2reg      = 1'b0;
                e.nxt.mem_write    = 1'b0;
                e.nxt.br_addr_mode = 1'b0;
                e.nxt.regs_write   = 1'b0;
                e.nxt.alu_op       = 3'b111;
                e.nxt.alu_src1     = 2'b00;
                e.nxt.alu_src2     = 2'b00;
            end
        end
        e.bcnt     = m_bcnt;
        m_ex       = e.nxt;
        last_stall = e.stall;
        sb_q.push_back(e);
    endtask

    task automatic stimulus();
        ex_t cur;
        ex_t dep;
        repeat (2) @(posedge clk);
        m_ex   = nop_slot();
        m_bcnt = 0;
        step(rand_id(), 1'b0, 1'b1);

        // plain pass-through of an ALU op writing x5
        cur = mk_id(5'd5, 5'd1, 5'd2, 1'b0);
        cur.regs_write = 1'b1;
        cur.alu_op     = 3'b010;
        step(cur, 1'b0, 1'b0);

        // load x7 then a consumer of x7 via rs2, re-presented after the stall
        step(mk_id(5'd7, 5'd1, 5'd2, 1'b1), 1'b0, 1'b0);
        dep = mk_id(5'd8, 5'd3, 5'd7, 1'b0);
        step(dep, 1'b0, 1'b0);
        step(dep, 1'b0, 1'b0);

        // load into x0 never interlocks
        step(mk_id(5'd0, 5'd1, 5'd2, 1'b1), 1'b0, 1'b0);
        step(mk_id(5'd4, 5'd0, 5'd0, 1'b0), 1'b0, 1'b0);

        // flush together with a load-use hazard counts once
        step(mk_id(5'd9, 5'd1, 5'd2, 1'b1), 1'b0, 1'b0);
        cur = mk_id(5'd10, 5'd9, 5'd11, 1'b0);
        cur.mem_write = 1'b1;
        step(cur, 1'b1, 1'b0);

        // saturate the 4-bit counter and keep flushing
        repeat (20) step(rand_id(), 1'b1, 1'b0);

        // reset arriving while a stall is pending
        step(mk_id(5'd3, 5'd1, 5'd2, 1'b1), 1'b0, 1'b0);
        dep = mk_id(5'd12, 5'd3, 5'd13, 1'b0);
        step(dep, 1'b0, 1'b0);
        step(dep, 1'b0, 1'b1);
        step(dep, 1'b0, 1'b0);

        for (int i = 0; i < 500; i++) begin
            logic fl;
            logic rs;
            fl = ($urandom_range(0, 9) == 0);
            rs = ($urandom_range(0, 39) == 0);
            if (!last_stall) begin
                cur = rand_id();
                cur.mem_read = $urandom_range(0, 1);
                case ($urandom_range(0, 3))
                    0: cur.rs1 = m_ex.rd;
                    1: cur.rs2 = m_ex.rd;
                    default: ;
                endcase
                if ($urandom_range(0, 7) == 0) cur.rd = 5'd0;
            end
            step(cur, fl, rs);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic monitor();
        int idle = 0;
        int cyc  = 0;
        while (!(stim_done && sb_q.size() == 0)) begin
            @(negedge clk);
            if (sb_q.size() == 0) begin
                idle++;
                if (idle > 50) begin
                    checks++;
                    $display("FAIL scoreboard_timeout: queue empty for %0d cycles, required a pending transaction", idle);
                    break;
                end
                continue;
            end
            idle = 0;
            checks++;
            if (hazard_stall === sb_q[0].stall) passes++;
            else $display("FAIL hazard_stall txn %0d: got %b required %b", cyc, hazard_stall, sb_q[0].stall);
            @(posedge clk);
            #1;
            checks++;
            if (dut_ex === sb_q[0].nxt) passes++;
            else $display("FAIL ex_regs txn %0d: got %h required %h", cyc, dut_ex, sb_q[0].nxt);
            checks++;
            if (bubble_cnt === BCNT_W'(sb_q[0].bcnt)) passes++;
            else $display("FAIL bubble_cnt txn %0d: got %0d required %0d", cyc, bubble_cnt, sb_q[0].bcnt);
            void'(sb_q.pop_front());
            cyc++;
        end
    endtask

    initial begin
        fork
            begin
                stimulus();
                stim_done = 1'b1;
            end
            monitor();
        join
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
